seq_mag_cmp: RTL and testbench

- Parametrised multi-word magnitude comparator; successor to the 2-bit combinational equality block.
- Compares two operands of N_WORDS x W bits, streamed one word pair per beat, most-significant word first.
- Reports eq/gt/lt after the last beat, with a one-cycle done pulse.
- Sits between a word-serial data source (UART/FIFO frontend) and control logic that needs wide compares without a wide datapath.

---
 rtl/seq_cmp_pkg.sv | 34 +++
 rtl/seq_cmp_word.sv | 26 ++
 rtl/seq_mag_cmp.sv | 96 +++++++++
 tb/tb_seq_mag_cmp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seq_cmp_pkg.sv
// Shared types and the per-word compare helper for the word-serial magnitude comparator.
// SEQ_MAG_CMP_SIGNED_EN makes the most-significant word compare as two's complement.
package seq_cmp_pkg;

  localparam int unsigned CMP_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  // Words arrive left-aligned, so the sign bit of any word width is the top bit.
  function automatic logic [1:0] cmp_word(input logic [CMP_MAX_W-1:0] a,
                                          input logic [CMP_MAX_W-1:0] b,
                                          input logic                 is_msw);
    logic greater_u;
    logic greater_msw;
    greater_u = a > b;
`ifdef SEQ_MAG_CMP_SIGNED_EN
    greater_msw = $signed(a) > $signed(b);
`else
    greater_msw = greater_u;
`endif
    return {a != b, is_msw ? greater_msw : greater_u};
  endfunction

endpackage

// File: rtl/seq_cmp_word.sv
// Combinational per-word differs/greater unit; signedness of the MSW follows
// SEQ_MAG_CMP_SIGNED_EN through seq_cmp_pkg::cmp_word.
module seq_cmp_word
  import seq_cmp_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_word,
  input  logic [W-1:0] b_word,
  input  logic         is_msw,
  output logic         differs,
  output logic         greater
);

  logic [CMP_MAX_W-1:0] a_al;
  logic [CMP_MAX_W-1:0] b_al;
  logic [1:0]           res;

  assign a_al = CMP_MAX_W'(a_word) << (CMP_MAX_W - W);
  assign b_al = CMP_MAX_W'(b_word) << (CMP_MAX_W - W);
  assign res  = cmp_word(a_al, b_al, is_msw);

  assign differs = res[1];
  assign greater = res[0];

endmodule

// File: rtl/seq_mag_cmp.sv
// Word-serial N_WORDS x W magnitude comparator, MSW first; eq/gt/lt held, one-cycle done.
// Define SEQ_MAG_CMP_SIGNED_EN to treat the whole operand as two's complement.
module seq_mag_cmp
  import seq_cmp_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned N_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_word,
  input  logic [W-1:0] b_word,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int unsigned     CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_WORDS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q;
  logic             greater_q;
  result_t          res_q;

  logic beat;
  logic is_msw;
  logic word_differs;
  logic word_greater;
  logic decided_n;
  logic greater_n;

  seq_cmp_word #(.W(W)) u_word (
    .a_word  (a_word),
    .b_word  (b_word),
    .is_msw  (is_msw),
    .differs (word_differs),
    .greater (word_greater)
  );

  assign is_msw   = (cnt_q == '0);
  assign in_ready = (state_q == RUN);
  assign beat     = in_valid & in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign eq       = res_q.eq;
  assign gt       = res_q.gt;
  assign lt       = res_q.lt;

  // First differing word decides; later words only ride along.
  assign decided_n = decided_q | word_differs;
  assign greater_n = decided_q ? greater_q : word_greater;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      greater_q <= 1'b0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            greater_q <= 1'b0;
          end
        end
        RUN: begin
          if (beat) begin
            decided_q <= decided_n;
            greater_q <= greater_n;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q  <= DONE;
              res_q.eq <= ~decided_n;
              res_q.gt <= decided_n & greater_n;
              res_q.lt <= decided_n & ~greater_n;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed bench for seq_mag_cmp: a W=8/N_WORDS=4 instance and an N_WORDS=1 instance.
// Expected results follow SEQ_MAG_CMP_SIGNED_EN when the bench is built with it.
module tb_seq_mag_cmp;

  localparam int unsigned W  = 8;
  localparam int unsigned NW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, in_valid = 1'b0;
  logic [W-1:0] a_word = '0, b_word = '0;
  logic         in_ready, busy, done, eq, gt, lt;

  logic         u1_start = 1'b0, u1_in_valid = 1'b0;
  logic [W-1:0] u1_a_word = '0, u1_b_word = '0;
  logic         u1_in_ready, u1_busy, u1_done, u1_eq, u1_gt, u1_lt;

  int unsigned n_chk = 0, n_fail = 0;
  int unsigned done_cnt = 0, done_cnt1 = 0;
  logic [2:0]  prev_res = 3'b000;

  seq_mag_cmp #(.W(W), .N_WORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a_word(a_word), .b_word(b_word), .busy(busy),
    .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  seq_mag_cmp #(.W(W), .N_WORDS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(u1_start), .in_valid(u1_in_valid),
    .in_ready(u1_in_ready), .a_word(u1_a_word), .b_word(u1_b_word), .busy(u1_busy),
    .done(u1_done), .eq(u1_eq), .gt(u1_gt), .lt(u1_lt)
  );

  always @(negedge clk) begin
    if (done)    done_cnt++;
    if (u1_done) done_cnt1++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full compare on the 4-word instance; optional stall before beat stall_at.
  task automatic run4(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input int unsigned stall_at, input int unsigned stall_len,
                      input logic [2:0] exp_res, input logic start_in_run);
    int unsigned n;
    int unsigned dc0;
    int unsigned stalls;
    dc0    = done_cnt;
    stalls = (stall_at < NW) ? stall_len : 0;
    start  = 1'b1;
    n      = 1;
    chk({tag, "/idle_rdy"}, in_ready, 0);
    cyc(); n++;
    start = start_in_run;
    chk({tag, "/held"}, {eq, gt, lt}, prev_res);
    for (int i = 0; i < NW; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b0;
          chk({tag, "/stall_rdy"}, in_ready, 1);
          cyc(); n++;
        end
      end
      in_valid = 1'b1;
      a_word   = a[8*(NW-1-i) +: 8];
      b_word   = b[8*(NW-1-i) +: 8];
      chk({tag, "/beat_rdy"}, {in_ready, busy, done}, 3'b110);
      cyc(); n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, "/done"}, {done, busy, in_ready}, 3'b110);
    chk({tag, "/latency"}, n, NW + 2 + stalls);
    chk({tag, "/result"}, {eq, gt, lt}, exp_res);
    cyc();
    chk({tag, "/done_fall"}, {done, busy}, 2'b00);
    chk({tag, "/pulses"}, done_cnt - dc0, 1);
    chk({tag, "/hold"}, {eq, gt, lt}, exp_res);
    prev_res = exp_res;
  endtask

  initial begin
    logic [2:0] exp_signed;
    int unsigned dc0;

    #3;
    chk("reset_outs", {in_ready, busy, done, eq, gt, lt}, 6'b000000);
    chk("reset_outs1", {u1_in_ready, u1_busy, u1_done, u1_eq, u1_gt, u1_lt}, 6'b000000);
    #9 reset_n = 1'b1;
    cyc();

    run4("eq",   32'h12345678, 32'h12345678, NW, 0, 3'b100, 1'b0);
    run4("lt",   32'h12FF0000, 32'h13000000, NW, 0, 3'b001, 1'b0);
    run4("gt_stall", 32'hAABBCC02, 32'hAABBCC01, 2, 3, 3'b010, 1'b0);

    // Abort mid-run with an asynchronous reset pulse during beat 2.
    dc0 = done_cnt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a_word = 8'h10; b_word = 8'h10;
      cyc();
    end
    a_word = 8'h20; b_word = 8'h01;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {in_ready, busy, done, eq, gt, lt}, 6'b000000);
    #1 reset_n = 1'b1;
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst_mid_idle", {busy, done, eq, gt, lt}, 5'b00000);
    chk("rst_no_done", done_cnt - dc0, 0);
    prev_res = 3'b000;

    run4("zero_start_in_run", 32'h00000000, 32'h00000000, NW, 0, 3'b100, 1'b1);
    cyc(); cyc();
    chk("no_restart", {busy, done}, 2'b00);

`ifdef SEQ_MAG_CMP_SIGNED_EN
    exp_signed = 3'b001;
`else
    exp_signed = 3'b010;
`endif
    run4("sign", 32'h80000000, 32'h7FFFFFFF, NW, 0, exp_signed, 1'b0);

    // Single-word instance: start and in_valid together must not consume a beat.
    u1_start = 1'b1; u1_in_valid = 1'b1; u1_a_word = 8'h05; u1_b_word = 8'h05;
    chk("w1_idle_rdy", u1_in_ready, 0);
    cyc();
    u1_start = 1'b0;
    chk("w1_run", {u1_in_ready, u1_busy, u1_done}, 3'b110);
    cyc();
    u1_in_valid = 1'b0;
    chk("w1_eq_done", {u1_done, u1_eq, u1_gt, u1_lt}, 4'b1100);
    cyc();
    chk("w1_eq_fall", {u1_done, u1_busy, u1_eq}, 3'b001);

    u1_start = 1'b1;
    cyc();
    u1_start = 1'b0; u1_in_valid = 1'b1; u1_a_word = 8'h06; u1_b_word = 8'h05;
    cyc();
    u1_in_valid = 1'b0;
    chk("w1_gt_done", {u1_done, u1_eq, u1_gt, u1_lt}, 4'b1010);
    cyc();
    chk("w1_pulses", done_cnt1, 2);
    chk("dut0_pulses", done_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
